// File: rtl/demux1to16_deser.sv
// rtl/demux1to16_deser.sv - 1-to-WIDTH serial demultiplexer with valid/ready word output
module demux1to16_deser #(
   parameter int WIDTH = 16,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               din_sof,
   output logic               din_ready,
   output logic [SEL_W-1:0]   slot,
   output logic [0:WIDTH-1]   W,
   output logic               w_valid,
   input  logic               w_ready,
   output logic               frame_err
);

   logic [SEL_W-1:0] slot_q, slot_d;
   logic [0:WIDTH-1] asm_q, asm_d;
   logic [0:WIDTH-1] w_q, w_d;
   logic             asm_full_q, asm_full_d;
   logic             w_valid_q, w_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [0:WIDTH-1] word;
   logic             accept;
   logic             out_free;

   assign din_ready = !asm_full_q;
   assign accept    = din_valid && din_ready;
   assign out_free  = !w_valid_q || w_ready;

   always_comb begin
      slot_d      = slot_q;
      asm_d       = asm_q;
      w_d         = w_q;
      asm_full_d  = asm_full_q;
      w_valid_d   = w_valid_q;
      frame_err_d = 1'b0;
      word        = asm_q;

      if (w_valid_q && w_ready) begin
         w_valid_d = 1'b0;
      end

      // A held word moves to the output as soon as the output register frees.
      if (asm_full_q && out_free) begin
         w_d        = asm_q;
         w_valid_d  = 1'b1;
         asm_full_d = 1'b0;
      end

      if (accept) begin
         if (din_sof) begin
            asm_d[0]    = din;
            slot_d      = SEL_W'(1);
            frame_err_d = (slot_q != '0);
         end else begin
            word[slot_q] = din;
            if (slot_q == SEL_W'(WIDTH - 1)) begin
               slot_d = '0;
               if (out_free) begin
                  w_d       = word;
                  w_valid_d = 1'b1;
               end else begin
                  asm_d      = word;
                  asm_full_d = 1'b1;
               end
            end else begin
               asm_d  = word;
               slot_d = slot_q + SEL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q      <= '0;
         asm_q       <= '0;
         w_q         <= '0;
         asm_full_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         asm_q       <= asm_d;
         w_q         <= w_d;
         asm_full_q  <= asm_full_d;
         w_valid_q   <= w_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign slot      = slot_q;
   assign W         = w_q;
   assign w_valid   = w_valid_q;
   assign frame_err = frame_err_q;

endmodule
